// File: rtl/digit_classifier_if.sv
// Result handshake between the network core, the classifier and the UI.
// DIGIT_CLASSIFIER_TOP2_EN adds the runner-up digit and the winning margin.
interface digit_classifier_if #(
  parameter int N_CLASSES = 10
);
  logic                       ready;
  logic [N_CLASSES-1:0][15:0] probability;
  logic                       clear;
  logic                       busy;
  logic                       valid;
  logic [3:0]                 digit;
  logic [15:0]                confidence;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
  logic [3:0]                 runner;
  logic [15:0]                margin;

  modport master (
    output ready, probability, clear,
    input  busy, valid, digit, confidence,
    input  runner, margin
  );

  modport slave (
    input  ready, probability, clear,
    output busy, valid, digit, confidence,
    output runner, margin
  );
`else
  modport master (
    output ready, probability, clear,
    input  busy, valid, digit, confidence
  );

  modport slave (
    input  ready, probability, clear,
    output busy, valid, digit, confidence
  );
`endif
endinterface

// File: rtl/digit_classifier.sv
// Snapshots the network output vector and scans it one entry per clock.
// DIGIT_CLASSIFIER_TOP2_EN adds second-best tracking and margin rejection.
module digit_classifier #(
  parameter int          N_CLASSES = 10,
  parameter logic [15:0] MIN_CONF  = 16'd1024
) (
  input logic               clk,
  input logic               rst,
  digit_classifier_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SCAN,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(N_CLASSES - 1);
  localparam logic [3:0] NONE = 4'hF;

  state_t                     state;
  state_t                     state_n;
  logic                       ready_q;
  logic                       rise;
  logic [N_CLASSES-1:0][15:0] snap;
  logic [3:0]                 idx;
  logic [3:0]                 best_idx;
  logic [15:0]                best_val;
  logic [15:0]                cur;
  logic                       take;
  logic                       accept;
  logic                       valid;
  logic [3:0]                 digit;
  logic [15:0]                confidence;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
  logic [3:0]                 second_idx;
  logic [15:0]                second_val;
  logic [15:0]                gap;
  logic [3:0]                 runner;
  logic [15:0]                margin;
`endif

  assign rise = bus.ready & ~ready_q;
  assign cur  = snap[idx];
  assign take = (idx == 4'd0) || (cur > best_val);

`ifdef DIGIT_CLASSIFIER_TOP2_EN
  // second never exceeds best, so the gap cannot underflow
  assign gap    = best_val - second_val;
  assign accept = (best_val >= MIN_CONF) && (gap >= (MIN_CONF >> 2));
`else
  assign accept = best_val >= MIN_CONF;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (rise) state_n = CAPTURE;
      CAPTURE: state_n = SCAN;
      SCAN:    if (idx == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.clear) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      snap       <= '0;
      idx        <= 4'd0;
      best_idx   <= 4'd0;
      best_val   <= 16'd0;
      valid      <= 1'b0;
      digit      <= NONE;
      confidence <= 16'd0;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
      second_idx <= 4'd0;
      second_val <= 16'd0;
      runner     <= NONE;
      margin     <= 16'd0;
`endif
    end else begin
      ready_q <= bus.ready;
      valid   <= 1'b0;
      if (bus.clear) begin
        digit      <= NONE;
        confidence <= 16'd0;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
        runner     <= NONE;
        margin     <= 16'd0;
`endif
      end else begin
        unique case (state)
          CAPTURE: begin
            snap     <= bus.probability;
            idx      <= 4'd0;
            best_idx <= 4'd0;
            best_val <= 16'd0;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
            second_idx <= 4'd0;
            second_val <= 16'd0;
`endif
          end
          SCAN: begin
            idx <= idx + 4'd1;
            if (take) begin
              best_val <= cur;
              best_idx <= idx;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
              second_val <= best_val;
              second_idx <= best_idx;
            end else if (cur > second_val) begin
              second_val <= cur;
              second_idx <= idx;
`endif
            end
          end
          DONE: begin
            valid      <= 1'b1;
            digit      <= accept ? best_idx : NONE;
            confidence <= best_val;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
            runner     <= second_idx;
            margin     <= gap;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.valid      = valid;
  assign bus.digit      = digit;
  assign bus.confidence = confidence;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
  assign bus.runner     = runner;
  assign bus.margin     = margin;
`endif
endmodule

// File: tb/tb_digit_classifier.sv
// Scoreboard bench for digit_classifier: expectations queued at launch,
// checked on each Valid pulse including the exact Valid cycle.
module tb_digit_classifier;
  typedef logic [9:0][15:0] vec_t;

  typedef struct {
    logic [3:0]  digit;
    logic [15:0] conf;
    logic [3:0]  runner;
    logic [15:0] margin;
    bit          chk2;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   vcount;
  exp_t sbq[$];
  exp_t me;

  digit_classifier_if #(.N_CLASSES(10)) bus ();

  digit_classifier #(
    .N_CLASSES(10),
    .MIN_CONF (16'd1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.valid === 1'b1) begin
      vcount++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid cyc=%0d digit=%0h conf=%0d",
                 cyc, bus.digit, bus.confidence);
      end else begin
        me = sbq.pop_front();
        if (bus.digit !== me.digit || bus.confidence !== me.conf ||
            cyc !== me.cyc) begin
          bad++;
          $display("FAIL result got d=%0h c=%0d cyc=%0d want d=%0h c=%0d cyc=%0d",
                   bus.digit, bus.confidence, cyc, me.digit, me.conf, me.cyc);
        end
`ifdef DIGIT_CLASSIFIER_TOP2_EN
        if (me.chk2) begin
          total++;
          if (bus.runner !== me.runner || bus.margin !== me.margin) begin
            bad++;
            $display("FAIL top2 got r=%0d m=%0d want r=%0d m=%0d",
                     bus.runner, bus.margin, me.runner, me.margin);
          end
        end
`endif
      end
    end
  end

  function automatic vec_t fill(input logic [15:0] base);
    vec_t v;
    for (int i = 0; i < 10; i++) v[i] = base;
    return v;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    int b;
    int s;
    bit ok;
    b = 0;
    s = -1;
    for (int i = 1; i < 10; i++) if (v[i] > v[b]) b = i;
    for (int i = 0; i < 10; i++)
      if (i != b && (s < 0 || v[i] > v[s])) s = i;
    e.conf   = v[b];
    e.runner = 4'(s);
    e.margin = v[b] - v[s];
    ok = v[b] >= 16'd1024;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
    ok = ok && (e.margin >= 16'd256);
`endif
    e.digit = ok ? 4'(b) : 4'hF;
    e.chk2  = 1'b1;
    e.cyc   = 0;
    return e;
  endfunction

  function automatic exp_t expd(input logic [3:0] d, input logic [15:0] c);
    exp_t e;
    e.digit  = d;
    e.conf   = c;
    e.runner = 4'h0;
    e.margin = 16'd0;
    e.chk2   = 1'b0;
    e.cyc    = 0;
    return e;
  endfunction

  task automatic launch(input vec_t v, input exp_t e);
    @(negedge clk);
    bus.probability = v;
    bus.ready = 1'b1;
    e.cyc = cyc + 13;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus.busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL %s timeout pending=%0d busy=%b", name, sbq.size(), bus.busy);
      sbq.delete();
    end
    bus.ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total += 4;
    if (bus.digit !== 4'hF) begin
      bad++;
      $display("FAIL reset_digit got %0h want f", bus.digit);
    end
    if (bus.confidence !== 16'd0) begin
      bad++;
      $display("FAIL reset_conf got %0d want 0", bus.confidence);
    end
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got %b want 0", bus.valid);
    end
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_peak();
    vec_t v;
    v = fill(16'd50);
    v[7] = 16'd1900;
    launch(v, expd(4'd7, 16'd1900));
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if (bus.busy !== (k < 12)) begin
        bad++;
        $display("FAIL busy_e%0d got %b want %b", k, bus.busy, k < 12);
      end
    end
    drain("single_peak");
  endtask

  task automatic test_tie_reject();
    vec_t v;
    v = fill(16'd0);
    v[2] = 16'd1500;
    v[5] = 16'd1500;
`ifdef DIGIT_CLASSIFIER_TOP2_EN
    launch(v, expd(4'hF, 16'd1500));
`else
    launch(v, expd(4'd2, 16'd1500));
`endif
    drain("tie");
    launch(fill(16'd900), expd(4'hF, 16'd900));
    drain("reject");
  endtask

  task automatic test_hold_ready();
    vec_t v;
    int pv;
    v = fill(16'd10);
    v[4] = 16'd3000;
    pv = vcount;
    launch(v, expd(4'd4, 16'd3000));
    repeat (40) @(negedge clk);
    total++;
    if (vcount - pv !== 1) begin
      bad++;
      $display("FAIL hold_ready valids got %0d want 1", vcount - pv);
    end
    drain("hold_ready");
  endtask

  task automatic test_repulse();
    vec_t v;
    int pv;
    v = fill(16'd100);
    v[0] = 16'd1200;
    pv = vcount;
    launch(v, expd(4'd0, 16'd1200));
    repeat (3) @(negedge clk);
    bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.ready = 1'b1;
    drain("repulse");
    repeat (3) @(negedge clk);
    total++;
    if (vcount - pv !== 1) begin
      bad++;
      $display("FAIL repulse valids got %0d want 1", vcount - pv);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v;
    v = fill(16'd20);
    v[9] = 16'd2100;
    launch(v, expd(4'd9, 16'd2100));
    drain("b2b_a");
    v = fill(16'd20);
    v[6] = 16'd40000;
    launch(v, expd(4'd6, 16'd40000));
    drain("b2b_b");
  endtask

  task automatic test_clear();
    vec_t v;
    int pv;
    v = fill(16'd5);
    v[8] = 16'd1800;
    launch(v, expd(4'd8, 16'd1800));
    repeat (6) @(negedge clk);
    bus.clear = 1'b1;
    sbq.delete();
    pv = vcount;
    @(negedge clk);
    bus.clear = 1'b0;
    total += 4;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_busy got %b want 0", bus.busy);
    end
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_valid got %b want 0", bus.valid);
    end
    if (bus.digit !== 4'hF) begin
      bad++;
      $display("FAIL clear_digit got %0h want f", bus.digit);
    end
    if (bus.confidence !== 16'd0) begin
      bad++;
      $display("FAIL clear_conf got %0d want 0", bus.confidence);
    end
    repeat (20) @(negedge clk);
    total++;
    if (vcount !== pv) begin
      bad++;
      $display("FAIL clear_retrigger valids got %0d want 0", vcount - pv);
    end
    bus.ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    vec_t v;
    v = fill(16'd1);
    v[3] = 16'd1500;
    launch(v, expd(4'd3, 16'd1500));
    drain("pre_reset");
    launch(v, expd(4'd3, 16'd1500));
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    bus.ready = 1'b0;
    sbq.delete();
    #1;
    total += 3;
    if (bus.digit !== 4'hF || bus.confidence !== 16'd0) begin
      bad++;
      $display("FAIL areset_out got d=%0h c=%0d want f/0",
               bus.digit, bus.confidence);
    end
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL areset_busy got %b want 0", bus.busy);
    end
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL areset_valid got %b want 0", bus.valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    vec_t v;
    vec_t w;
    v = fill(16'd50);
    v[7] = 16'd1900;
    w = fill(16'd50);
    w[3] = 16'd2000;
    launch(v, expd(4'd7, 16'd1900));
    repeat (4) @(negedge clk);
    bus.probability = w;
    drain("snapshot");
  endtask

  task automatic test_random();
    vec_t v;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 10; i++) v[i] = 16'($urandom_range(1, 1500));
      if (t % 2 == 0) v[$urandom_range(0, 9)] = 16'($urandom_range(1024, 4000));
      launch(v, model(v));
      drain("random");
    end
  endtask

`ifdef DIGIT_CLASSIFIER_TOP2_EN
  task automatic test_top2();
    vec_t v;
    exp_t e;
    v = fill(16'd0);
    v[1] = 16'd1800;
    v[9] = 16'd1700;
    e = expd(4'hF, 16'd1800);
    e.runner = 4'd9;
    e.margin = 16'd100;
    e.chk2 = 1'b1;
    launch(v, e);
    drain("top2_close");
    v[9] = 16'd1000;
    e = expd(4'd1, 16'd1800);
    e.runner = 4'd9;
    e.margin = 16'd800;
    e.chk2 = 1'b1;
    launch(v, e);
    drain("top2_wide");
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    vcount = 0;
    bus.ready = 1'b0;
    bus.clear = 1'b0;
    bus.probability = '0;
    rst = 1'b1;
    test_reset();
    test_single_peak();
    test_tie_reject();
    test_hold_ready();
    test_repulse();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_snapshot();
    test_random();
`ifdef DIGIT_CLASSIFIER_TOP2_EN
    test_top2();
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digit_classifier.md
Name: digit_classifier

Overview:
- Sits directly downstream of the neural network core; consumes its 10-entry output probability vector and its Ready flag.
- On each new inference result, snapshots the vector and scans it sequentially, one entry per clock, to find the most probable digit.
- Presents a registered digit, confidence and one-cycle Valid pulse to the display/UI logic.
- Rejects low-confidence results by reporting digit 4'hF.

Parameters:
- N_CLASSES, 10, number of probability entries scanned (index width fixed at 4 bits).
- MIN_CONF, 16'd1024, rejection threshold in Q5.11 (1<<11 = 1.0); default is 0.5.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Ready  input  1  network result flag; level, may stay high for many cycles.
- Probability  input  16 x [N_CLASSES-1:0]  unsigned Q5.11 sigmoid outputs, index = digit.
- Clear  input  1  synchronous abort/clear request.
- Busy  output  1  high in CAPTURE, SCAN and DONE states.
- Valid  output  1  one-cycle pulse when Digit/Confidence update.
- Digit  output  4  winning digit 0-9, or 4'hF when rejected or cleared.
- Confidence  output  16  winning probability, raw Q5.11.

Behaviour:
- Reset (async): state IDLE; Busy=0, Valid=0, Digit=4'hF, Confidence=0; snapshot, best and index registers = 0; Ready edge history = 0.
- Ready is edge-detected with a registered copy. A rise is Ready=1 while the registered copy =0.
- FSM: IDLE -> CAPTURE -> SCAN -> DONE -> IDLE.
- IDLE:
  - On a Ready rise, go to CAPTURE.
  - Probability is not sampled yet; the network updates it on the cycle Ready is first high.
- CAPTURE (1 cycle):
  - Latch all Probability entries into the internal snapshot.
  - Set idx=0, best_val=0, best_idx=0.
  - Go to SCAN.
- SCAN (N_CLASSES cycles):
  - Each cycle compare snap[idx] against best_val.
  - idx=0 loads unconditionally.
  - For idx>0, replace only if snap[idx] > best_val (strict). Ties go to the lowest index.
  - idx increments each cycle; after idx = N_CLASSES-1, go to DONE.
- DONE (1 cycle):
  - Register Digit = (best_val >= MIN_CONF) ? best_idx : 4'hF, and Confidence = best_val.
  - Valid=1 for exactly this cycle; then go to IDLE.
- Latency: first edge sampling Ready=1 is E0. CAPTURE occupies E0-E1, SCAN E1-E11, and Valid is high from E12 to E13. Total: 12 cycles from Ready rise to Valid.
- Ready rises during CAPTURE/SCAN/DONE are ignored (no restart, no queuing). Ready held high after DONE does not retrigger.
- Clear: synchronous, priority over everything except Reset.
  - In any state: return to IDLE, Digit=4'hF, Confidence=0, Valid=0.
  - The edge detector still updates, so a Ready already high does not retrigger.
- Comparisons are unsigned 16-bit. Values above 1.0 (>2048) are accepted as-is.
- Digit and Confidence hold their last value between results.
- Busy is a combinational decode of state.

Optional Feature:
- Macro: DIGIT_CLASSIFIER_TOP2_EN.
- Enabled:
  - Adds outputs Runner[3:0] and Margin[15:0].
  - SCAN also tracks the second-best entry: when a new best is found, the old best moves to second. When snap[idx] > second_val but is not > best_val, it replaces second.
  - At DONE: Runner = second_idx, Margin = best_val - second_val (never negative).
  - Reset/Clear values: Runner=4'hF, Margin=0.
  - A result is also rejected (Digit=4'hF) if Margin < MIN_CONF/4.
- Disabled: ports absent, no second-best logic; rejection depends only on MIN_CONF.

Test Plan:
- Single peak: Probability[7]=16'd1900, all others 16'd50; Ready rises at E0. Required: Busy during E0-E12, Valid pulse from E12 to E13, Digit=7, Confidence=1900.
- Tie and reject:
  - [2]=[5]=16'd1500, rest 0. Required: Digit=2 (lowest index wins).
  - Repeat with all entries 16'd900. Required: Digit=4'hF, Confidence=900.
- Retrigger rules:
  - Ready held high 40 cycles. Required: exactly one Valid.
  - Ready pulsed again at E5. Required: ignored, single Valid at E12.
  - Ready dropped and re-raised after DONE. Required: new result.
- Clear/Reset mid-scan:
  - Clear at E6. Required: IDLE next cycle, no Valid, Digit=4'hF, Confidence=0.
  - Async Reset at E8 between edges. Required: outputs at reset values immediately.
- Snapshot isolation: change Probability to a different peak ([3]=2000) at E4. Required: result still reflects values latched at E1.
- TOP2_EN build:
  - [1]=1800, [9]=1700. Required: Digit=4'hF (margin 100 < 256), Runner=9, Margin=100.
  - [1]=1800, [9]=1000. Required: Digit=1, Margin=800.
